// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port memory between an instruction-fetch
// port and a load/store data port.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   if_req/if_addr           fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata fetch grant, and the 32-bit instruction one cycle later
//   d_req/d_we/d_addr/d_wdata/d_wmask  data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata   data grant, and the raw load word one cycle later
//   mem_en/mem_we/mem_addr/mem_wdata/mem_wmask  memory strobe and write side
//   mem_rdata                memory read data, valid the cycle after a read strobe
//
// Grants are combinational in the request cycle. Conflicts go round-robin
// on a registered last-grant bit, so each side waits at most one cycle.
// The memory word is 64 bits wide; a fetch selects one half by if_addr[2].
module ram_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [31:0]         if_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wmask,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic [DATA_W-1:0]   mem_rdata
);

   typedef enum logic {LG_INST, LG_DATA} lg_t;
   typedef enum logic [1:0] {P_NONE, P_INST, P_DATA} pend_t;

   lg_t   last_q, last_n;
   pend_t pend_q, pend_n;
   logic  hi_q, hi_n;   // which half of the word the pending fetch wants

   // Grant: a lone requester always wins; on conflict the side not granted
   // last wins. Reset blocks every grant.
   always_comb begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
      if (!rst) begin
         if (if_req && d_req) begin
            if (last_q == LG_DATA) if_gnt = 1'b1;
            else                   d_gnt  = 1'b1;
         end else begin
            if_gnt = if_req;
            d_gnt  = d_req;
         end
      end
   end

   assign mem_en    = if_gnt | d_gnt;
   assign mem_we    = d_gnt & d_we;
   assign mem_addr  = d_gnt ? d_addr : if_addr;
   assign mem_wdata = d_wdata;   // only meaningful while mem_we is high
   assign mem_wmask = mem_we ? d_wmask : '0;

   // Next state: last-grant moves only on a grant; the pending response
   // reflects only this cycle's read grant (stores expect no response).
   always_comb begin
      last_n = last_q;
      pend_n = P_NONE;
      hi_n   = hi_q;
      if (if_gnt) begin
         last_n = LG_INST;
         pend_n = P_INST;
         hi_n   = if_addr[2];
      end else if (d_gnt) begin
         last_n = LG_DATA;
         if (!d_we) pend_n = P_DATA;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= LG_DATA;   // first conflict after reset goes to fetch
         pend_q <= P_NONE;
         hi_q   <= 1'b0;
      end else begin
         last_q <= last_n;
         pend_q <= pend_n;
         hi_q   <= hi_n;
      end
   end

   // Reset in the response cycle drops the response; the requester reissues.
   assign if_rvalid = (pend_q == P_INST) & ~rst;
   assign d_rvalid  = (pend_q == P_DATA) & ~rst;
   assign if_rdata  = hi_q ? mem_rdata[63:32] : mem_rdata[31:0];
   assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model (turn bit, expected responses, reference memory).
module tb_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [63:0] if_addr = '0;
   logic        if_gnt, if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0, d_we = 1'b0;
   logic [63:0] d_addr = '0, d_wdata = '0;
   logic [7:0]  d_wmask = '0;
   logic        d_gnt, d_rvalid;
   logic [63:0] d_rdata;
   logic        mem_en, mem_we;
   logic [63:0] mem_addr, mem_wdata;
   logic [7:0]  mem_wmask;
   logic [63:0] mem_rdata;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ram_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wmask(d_wmask), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] pat(input int i);
      return {32'hC0DE_0000 + 32'(i), 32'h5EED_0000 + 32'(i)};
   endfunction

   // Memory environment: 8 words, reached through address bits [5:3].
   logic [63:0] env_mem [8];
   always @(posedge clk) begin
      if (mem_en && !mem_we) mem_rdata <= env_mem[mem_addr[5:3]];
      if (mem_we)
         for (int b = 0; b < 8; b++)
            if (mem_wmask[b]) env_mem[mem_addr[5:3]][8*b +: 8] <= mem_wdata[8*b +: 8];
   end

   // Behavioural model
   logic [63:0] ref_mem [8];
   bit          run_chk = 0;
   bit          m_turn_data = 0;   // 1: a conflict goes to data next
   bit          m_pend_i = 0, m_pend_d = 0;
   logic [31:0] m_i_data;
   logic [63:0] m_d_data;
   bit          eig, edg;
   bit          s_ig, s_dg;
   int          wait_i = 0, wait_d = 0;

   always @(negedge clk) if (run_chk) begin
      eig = !rst && if_req && (!d_req || !m_turn_data);
      edg = !rst && d_req && (!if_req || m_turn_data);
      chk("if_gnt", 64'(if_gnt), 64'(eig));
      chk("d_gnt", 64'(d_gnt), 64'(edg));
      chk("mem_en", 64'(mem_en), 64'(eig || edg));
      chk("mem_we", 64'(mem_we), 64'(edg && d_we));
      chk("mem_wmask", 64'(mem_wmask), (edg && d_we) ? 64'(d_wmask) : 64'd0);
      if (eig || edg) chk("mem_addr", mem_addr, eig ? if_addr : d_addr);
      if (edg && d_we) chk("mem_wdata", mem_wdata, d_wdata);
      chk("if_rvalid", 64'(if_rvalid), 64'(m_pend_i && !rst));
      chk("d_rvalid", 64'(d_rvalid), 64'(m_pend_d && !rst));
      if (m_pend_i && !rst) chk("if_rdata", 64'(if_rdata), 64'(m_i_data));
      if (m_pend_d && !rst) chk("d_rdata", d_rdata, m_d_data);
      // Starvation bound: a held request waits at most one cycle.
      wait_i = (if_req && !rst && !if_gnt) ? wait_i + 1 : 0;
      wait_d = (d_req && !rst && !d_gnt) ? wait_d + 1 : 0;
      if (if_req && d_req && !rst) begin
         chk("starve_i", 64'(wait_i <= 1), 64'd1);
         chk("starve_d", 64'(wait_d <= 1), 64'd1);
      end
      s_ig = if_gnt;
      s_dg = d_gnt;
   end

   always @(posedge clk) if (run_chk) begin
      if (rst) begin
         m_turn_data = 0;
         m_pend_i = 0;
         m_pend_d = 0;
      end else begin
         m_pend_i = eig;
         m_pend_d = edg && !d_we;
         if (eig) begin
            m_turn_data = 1;
            m_i_data = if_addr[2] ? ref_mem[if_addr[5:3]][63:32] : ref_mem[if_addr[5:3]][31:0];
         end
         if (edg) begin
            m_turn_data = 0;
            if (d_we) begin
               for (int b = 0; b < 8; b++)
                  if (d_wmask[b]) ref_mem[d_addr[5:3]][8*b +: 8] = d_wdata[8*b +: 8];
            end else begin
               m_d_data = ref_mem[d_addr[5:3]];
            end
         end
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         env_mem[i] <= pat(i);
         ref_mem[i] = pat(i);
      end
      env_mem[0] <= 64'h1111_2222_3333_4444;
      ref_mem[0] = 64'h1111_2222_3333_4444;

      // Reset with both requests high: nothing may be granted.
      step;
      run_chk = 1;
      if_req = 1; d_req = 1; d_addr = 64'h8;
      @(negedge clk);
      chk("rst_if_gnt", 64'(if_gnt), 64'd0);
      chk("rst_d_gnt", 64'(d_gnt), 64'd0);
      chk("rst_mem_en", 64'(mem_en), 64'd0);
      step;
      rst = 0; if_req = 0; d_req = 0;
      step;

      // Fetch from the upper half of word 0.
      if_req = 1; if_addr = 64'h8000_0004;
      @(negedge clk);
      chk("fetch_gnt", 64'(if_gnt), 64'd1);
      step;
      if_req = 0;
      @(negedge clk);
      chk("fetch_rvalid", 64'(if_rvalid), 64'd1);
      chk("fetch_rdata", 64'(if_rdata), 64'h1111_2222);
      step;

      // Store then load at 0x10.
      d_req = 1; d_we = 1; d_addr = 64'h10; d_wmask = 8'h0F; d_wdata = 64'hAABB_CCDD;
      @(negedge clk);
      chk("store_we", 64'(mem_we), 64'd1);
      chk("store_mask", 64'(mem_wmask), 64'h0F);
      step;
      d_we = 0;
      @(negedge clk);
      chk("store_no_rvalid", 64'(d_rvalid), 64'd0);
      step;
      d_req = 0;
      @(negedge clk);
      chk("load_rvalid", 64'(d_rvalid), 64'd1);
      chk("load_low", 64'(d_rdata[31:0]), 64'hAABB_CCDD);

      // Conflict from reset: I,D,I,D,I,D.
      rst = 1;
      step;
      rst = 0; if_req = 1; if_addr = 64'h8000_0008; d_req = 1; d_we = 0; d_addr = 64'h18;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("rr_seq", 64'({if_gnt, d_gnt}), (i % 2 == 0) ? 64'h2 : 64'h1);
         step;
      end
      if_req = 0; d_req = 0;
      step;

      // Back-to-back fetch, load, fetch.
      if_req = 1; if_addr = 64'h8000_0008;
      step;
      if_req = 0; d_req = 1; d_we = 0; d_addr = 64'h18;
      @(negedge clk);
      chk("b2b_if_rv", 64'({if_rvalid, d_rvalid}), 64'h2);
      step;
      d_req = 0; if_req = 1; if_addr = 64'h8000_0020;
      @(negedge clk);
      chk("b2b_d_rv", 64'({if_rvalid, d_rvalid}), 64'h1);
      chk("b2b_d_data", d_rdata, pat(3));
      step;
      if_req = 0;
      @(negedge clk);
      chk("b2b_if2_rv", 64'({if_rvalid, d_rvalid}), 64'h2);
      chk("b2b_if2_data", 64'(if_rdata), 64'(pat(4) & 64'hFFFF_FFFF));
      step;

      // Reset right after a load grant drops the response.
      d_req = 1; d_we = 0; d_addr = 64'h10;
      @(negedge clk);
      chk("rstld_gnt", 64'(d_gnt), 64'd1);
      step;
      d_req = 0; rst = 1;
      @(negedge clk);
      chk("rstld_no_rvalid", 64'(d_rvalid), 64'd0);
      step;
      rst = 0; if_req = 1; d_req = 1; if_addr = 64'h8000_0000; d_addr = 64'h10;
      @(negedge clk);
      chk("rstld_first_fetch", 64'(if_gnt), 64'd1);
      step;
      if_req = 0; d_req = 0;
      step;

      // Randomized traffic; requests stay stable until granted.
      for (int c = 0; c < 3000; c++) begin
         if (!if_req || s_ig) begin
            if_req  = ($urandom_range(0, 2) != 0);
            if_addr = 64'h8000_0000 | 64'($urandom_range(0, 15) << 2);
         end
         if (!d_req || s_dg) begin
            d_req   = ($urandom_range(0, 2) != 0);
            d_we    = $urandom_range(0, 1) == 1;
            d_addr  = 64'($urandom_range(0, 7) << 3);
            d_wdata = {$urandom, $urandom};
            d_wmask = 8'($urandom);
         end
         rst = ($urandom_range(0, 39) == 0);
         step;
      end
      rst = 0; if_req = 0; d_req = 0;
      step;
      step;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, address width of all address ports.
REQ-002 SHALL have parameter DATA_W, default 64, data width of the memory and data port (byte mask width DATA_W/8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port if_req  input  1  instruction-fetch request; held with if_addr stable until if_gnt.
REQ-006 SHALL have port if_addr  input  ADDR_W  fetch byte address, 4-byte aligned.
REQ-007 SHALL have port if_gnt  output  1  fetch accepted this cycle.
REQ-008 SHALL have port if_rvalid  output  1  fetch data valid, one pulse per granted fetch.
REQ-009 SHALL have port if_rdata  output  32  fetched instruction.
REQ-010 SHALL have port d_req  input  1  data request; held with d_we/d_addr/d_wdata/d_wmask stable until d_gnt.
REQ-011 SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-012 SHALL have port d_addr  input  ADDR_W  data byte address.
REQ-013 SHALL have port d_wdata  input  DATA_W  store data, already lane-aligned.
REQ-014 SHALL have port d_wmask  input  DATA_W/8  store byte enables.
REQ-015 SHALL have port d_gnt  output  1  data access accepted this cycle.
REQ-016 SHALL have port d_rvalid  output  1  load data valid, one pulse per granted load.
REQ-017 SHALL have port d_rdata  output  DATA_W  raw memory word for the load (sign extension is downstream).
REQ-018 SHALL have port mem_en  output  1  single-port memory access strobe.
REQ-019 SHALL have port mem_we  output  1  memory write enable.
REQ-020 SHALL have port mem_addr  output  ADDR_W  memory address.
REQ-021 SHALL have port mem_wdata  output  DATA_W  memory write data.
REQ-022 SHALL have port mem_wmask  output  DATA_W/8  memory byte enables.
REQ-023 SHALL have port mem_rdata  input  DATA_W  memory read data, valid the cycle after a read strobe.

Function
REQ-024 SHALL issue at most one memory access per cycle; mem_en = if_gnt | d_gnt; if_gnt and d_gnt SHALL never both be 1.
REQ-025 SHALL grant combinationally in the request cycle: only if_req -> if_gnt; only d_req -> d_gnt.
REQ-026 SHALL resolve if_req & d_req by round-robin on a registered last-grant bit (LG_INST/LG_DATA): grant the side not granted last.
REQ-027 SHALL update last-grant only on a cycle where a grant occurs; idle cycles hold it.
REQ-028 SHALL drive mem_addr/mem_wdata/mem_wmask/mem_we from the granted side; mem_we = d_gnt & d_we; mem_wmask = 0 unless a store is granted.
REQ-029 SHALL keep a pending-response register with states P_NONE, P_INST, P_DATA: next = P_INST on if_gnt, P_DATA on d_gnt & ~d_we, else P_NONE.
REQ-030 SHALL assert if_rvalid exactly when pending = P_INST, and d_rvalid exactly when pending = P_DATA (read latency 1 cycle after grant).
REQ-031 SHALL register if_addr[2] at if_gnt and drive if_rdata = mem_rdata[63:32] when it is 1, else mem_rdata[31:0].
REQ-032 SHALL drive d_rdata = mem_rdata unconditionally; it is meaningful only while d_rvalid = 1.
REQ-033 SHALL produce no rvalid for stores; store then load to the same address in consecutive grants SHALL return the stored data.
REQ-034 SHALL bound starvation: with both requests held continuously, each side is granted at least every second cycle.

Reset
REQ-035 SHALL, while rst = 1, force if_gnt = d_gnt = mem_en = mem_we = 0 and mem_wmask = 0, regardless of requests.
REQ-036 SHALL, on reset, set pending = P_NONE and last-grant = LG_DATA (first conflict goes to fetch).
REQ-037 SHALL, when rst is asserted the cycle after a read grant, suppress the corresponding rvalid; the requester reissues.

Verification
REQ-038 SHALL cover: fetch only, if_addr=0x8000_0004, mem word 0x1111_2222_3333_4444 -> if_gnt same cycle, next cycle if_rvalid=1, if_rdata=0x1111_2222.
REQ-039 SHALL cover: store d_addr=0x10, d_wmask=0x0F, d_wdata=0xAABB_CCDD, then load 0x10 -> mem_we pulse with mask 0x0F, no d_rvalid after store, load d_rvalid with low word 0xAABB_CCDD.
REQ-040 SHALL cover: if_req and d_req held high 6 cycles from reset -> grants I,D,I,D,I,D; never both gnts high.
REQ-041 SHALL cover: back-to-back fetch, load, fetch -> rvalids on cycles +1 each, each on the correct port, no cross-talk.
REQ-042 SHALL cover: rst asserted the cycle after a load grant -> d_rvalid stays 0; after release, first conflict grants fetch.
